// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, one iteration per clock, with upstream stall while iterating.
module ex_muldiv_unit #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [XLEN-1:0]   read_data1,
   input  logic [XLEN-1:0]   read_data2,
   input  logic [4:0]        RD_n,
   input  logic              flush,
   output logic              busy,
   output logic              stall,
   output logic              done,
   output logic [XLEN-1:0]   result,
   output logic [4:0]        RD_n_out
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};

   logic [1:0]          state_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [2:0]          op_r;
   logic [4:0]          rd_r;
   logic                neg_r;
   logic                spec_r;
   logic [2*XLEN-1:0]   acc_r;
   logic [XLEN-1:0]     b_r;

   logic                sa_s, sb_s, neg_s, div_zero_s, ovf_s;
   logic [XLEN-1:0]     mag_a_s, mag_b_s, spec_val_s;
   logic [XLEN:0]       mul_sum_s, rem_sh_s, diff_s;
   logic [2*XLEN-1:0]   mul_next_s, div_next_s, prod_s;
   logic [XLEN-1:0]     quo_s, rem_s, fix_val_s;

   // Operand decode in IDLE: signed magnitudes, result sign and special-case detection.
   always_comb begin
      sa_s       = read_data1[XLEN-1] & (op == OP_MUL || op == OP_MULH || op == OP_MULHSU ||
                                         op == OP_DIV || op == OP_REM);
      sb_s       = read_data2[XLEN-1] & (op == OP_MUL || op == OP_MULH ||
                                         op == OP_DIV || op == OP_REM);
      mag_a_s    = sa_s ? -read_data1 : read_data1;
      mag_b_s    = sb_s ? -read_data2 : read_data2;
      neg_s      = (op == OP_REM) ? sa_s : (sa_s ^ sb_s);
      div_zero_s = op[2] && (read_data2 == ZERO);
      ovf_s      = (op == OP_DIV || op == OP_REM) && (read_data1 == INT_MIN) &&
                   (read_data2 == ALL_ONES);
      if (div_zero_s) begin
         spec_val_s = op[1] ? read_data1 : ALL_ONES;
      end else begin
         spec_val_s = op[1] ? ZERO : INT_MIN;
      end
   end

   // One iteration step; acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide.
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, (acc_r[0] ? b_r : ZERO)};
      mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
      rem_sh_s   = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
      diff_s     = rem_sh_s - {1'b0, b_r};
      if (diff_s[XLEN]) begin
         div_next_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end else begin
         div_next_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end
   end

   // Sign fix-up and result selection; remainder inherits the dividend's sign via neg_r.
   always_comb begin
      prod_s = neg_r ? -acc_r : acc_r;
      quo_s  = neg_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
      rem_s  = neg_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
      if (spec_r) begin
         fix_val_s = acc_r[XLEN-1:0];
      end else begin
         case (op_r)
            3'b000:                 fix_val_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val_s = quo_s;
            3'b110, 3'b111:         fix_val_s = rem_s;
            default:                fix_val_s = ZERO;
         endcase
      end
   end

   assign busy  = (state_r != IDLE);
   assign stall = (start && state_r == IDLE) || (state_r == CALC) || (state_r == FIX);

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         op_r     <= 3'b000;
         rd_r     <= 5'd0;
         neg_r    <= 1'b0;
         spec_r   <= 1'b0;
         acc_r    <= {(2*XLEN){1'b0}};
         b_r      <= ZERO;
         done     <= 1'b0;
         result   <= ZERO;
         RD_n_out <= 5'd0;
      end else if (flush) begin
         state_r <= IDLE;
         done    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_r  <= op;
                  rd_r  <= RD_n;
                  neg_r <= neg_s;
                  cnt_r <= {CNT_W{1'b0}};
                  if (div_zero_s || ovf_s) begin
                     spec_r  <= 1'b1;
                     acc_r   <= {ZERO, spec_val_s};
                     state_r <= FIX;
                  end else begin
                     spec_r  <= 1'b0;
                     state_r <= CALC;
                     if (op[2]) begin
                        acc_r <= {ZERO, mag_a_s};
                        b_r   <= mag_b_s;
                     end else begin
                        acc_r <= {ZERO, mag_b_s};
                        b_r   <= mag_a_s;
                     end
                  end
               end
            end
            CALC: begin
               done  <= 1'b0;
               cnt_r <= cnt_r + CNT_ONE;
               acc_r <= op_r[2] ? div_next_s : mul_next_s;
               if (cnt_r == CNT_LAST) begin
                  state_r <= FIX;
               end
            end
            FIX: begin
               result   <= fix_val_s;
               RD_n_out <= rd_r;
               done     <= 1'b1;
               state_r  <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV64M cases, flush, reset and random ops.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [63:0] read_data1 = 64'd0;
   logic [63:0] read_data2 = 64'd0;
   logic [4:0]  RD_n = 5'd0;
   logic        flush = 1'b0;
   logic        busy, stall, done;
   logic [63:0] result;
   logic [4:0]  RD_n_out;

   int tests_run = 0;
   int tests_failed = 0;
   logic [68:0] sb_q[$];
   logic [63:0] last_result = 64'd0;

   ex_muldiv_unit #(.XLEN(64), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .read_data1(read_data1), .read_data2(read_data2), .RD_n(RD_n),
      .flush(flush), .busy(busy), .stall(stall), .done(done),
      .result(result), .RD_n_out(RD_n_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [63:0] a,
                                             input logic [63:0] b);
      logic [127:0] ea, eb, p;
      logic [63:0]  r;
      ea = {64'd0, a};
      eb = {64'd0, b};
      if (o == 3'b000 || o == 3'b001 || o == 3'b010) ea = {{64{a[63]}}, a};
      if (o == 3'b000 || o == 3'b001) eb = {{64{b[63]}}, b};
      p = ea * eb;
      case (o)
         3'b000: r = p[63:0];
         3'b001, 3'b010, 3'b011: r = p[127:64];
         3'b100: begin
            if (b == 64'd0) r = 64'hFFFF_FFFF_FFFF_FFFF;
            else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
               r = 64'h8000_0000_0000_0000;
            else r = $signed(a) / $signed(b);
         end
         3'b101: r = (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
         3'b110: begin
            if (b == 64'd0) r = a;
            else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = 64'd0;
            else r = $signed(a) % $signed(b);
         end
         default: r = (b == 64'd0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int exp_lat(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
      if (o[2] && b == 64'd0) return 1;
      if ((o == 3'b100 || o == 3'b110) && a == 64'h8000_0000_0000_0000 &&
          b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
      return 65;
   endfunction

   task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] r, input logic [63:0] exp_val);
      int   edges;
      int   lat;
      logic got_done;
      logic stall_ok;
      logic [68:0] ent;
      lat = exp_lat(o, a, b);
      sb_q.push_back({r, exp_val});
      @(negedge clk);
      op = o; read_data1 = a; read_data2 = b; RD_n = r; start = 1'b1;
      #1;
      check_eq("stall_e0", {63'd0, stall}, 64'd1);
      @(posedge clk);
      #1 start = 1'b0;
      edges = 0;
      got_done = 1'b0;
      stall_ok = 1'b1;
      while (edges < 200 && !got_done) begin
         @(negedge clk);
         if (done) begin
            got_done = 1'b1;
         end else begin
            if (!stall) stall_ok = 1'b0;
            @(posedge clk);
            edges++;
         end
      end
      check_eq("done_seen", {63'd0, got_done}, 64'd1);
      if (got_done) begin
         check_eq("latency", 64'(edges), 64'(lat));
         check_eq("stall_busy", {63'd0, stall_ok}, 64'd1);
         check_eq("stall_done", {63'd0, stall}, 64'd0);
         if (sb_q.size() == 0) begin
            check_eq("sb_empty", 64'd1, {63'd0, done});
         end else begin
            ent = sb_q.pop_front();
            check_eq("result", result, ent[63:0]);
            check_eq("rd_out", {59'd0, RD_n_out}, {59'd0, ent[68:64]});
            last_result = ent[63:0];
         end
         @(negedge clk);
         check_eq("done_pulse", {63'd0, done}, 64'd0);
      end
   endtask

   initial begin
      logic [2:0]  ro;
      logic [63:0] ra, rb;
      logic        seen;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_result", result, 64'd0);
      check_eq("rst_flags", {60'd0, busy, done, stall, 1'b0}, 64'd0);
      check_eq("rst_rd", {59'd0, RD_n_out}, 64'd0);
      rst = 1'b1;

      run_op(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'd0);
      run_op(3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op(3'b101, 64'd100, 64'd7, 5'd7, 64'd14);
      run_op(3'b111, 64'd100, 64'd7, 5'd8, 64'd2);
      run_op(3'b101, 64'h1234, 64'd0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op(3'b110, 64'h1234, 64'd0, 5'd10, 64'h1234);
      run_op(3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
             64'h8000_0000_0000_0000);
      run_op(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
             64'hFFFF_FFFF_FFFF_FFFF);

      // Flush in the middle of CALC: no done, result unchanged.
      @(negedge clk);
      op = 3'b000; read_data1 = 64'd7; read_data2 = 64'd9; RD_n = 5'd13; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (30) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check_eq("flush_busy", {63'd0, busy}, 64'd0);
      check_eq("flush_done", {63'd0, done}, 64'd0);
      check_eq("flush_result", result, last_result);
      seen = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check_eq("flush_no_done", {63'd0, seen}, 64'd0);
      run_op(3'b000, 64'd3, 64'd5, 5'd14, 64'd15);

      // Reset in the middle of CALC clears every output.
      @(negedge clk);
      op = 3'b100; read_data1 = 64'd1000; read_data2 = 64'd3; RD_n = 5'd15; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_result", result, 64'd0);
      check_eq("mid_rst_flags", {61'd0, busy, done, stall}, 64'd0);
      check_eq("mid_rst_rd", {59'd0, RD_n_out}, 64'd0);
      run_op(3'b111, 64'd1000, 64'd3, 5'd5, 64'd1);

      for (int i = 0; i < 10; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (i % 4 == 1) rb = 64'($urandom_range(0, 9));
         if (i % 4 == 3) ra = -ra;
         run_op(ro, ra, rb, 5'(i + 16), ref_model(ro, ra, rb));
      end

      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched operands, destination register number and M-extension op. Produces a 64-bit result and destination for the EX/MEM register.
- Asserts stall to freeze the IF, ID and ID/EX stages while iterating.
- One iteration per cycle; radix-2 shift-add multiply and restoring divide.

Parameters:
XLEN, 64, operand/result width (only 64 is supported)
CNT_W, 6, iteration counter width (log2 XLEN)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (rst==0 at a rising edge resets)
start  input  1  ID/EX holds a valid M-extension op; sampled only in IDLE
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
read_data1  input  64  rs1 operand (dividend / multiplicand)
read_data2  input  64  rs2 operand (divisor / multiplier)
RD_n  input  5  destination register number
flush  input  1  synchronous abort from branch/exception logic
busy  output  1  operation in progress (state != IDLE)
stall  output  1  freeze upstream: start&IDLE | CALC | FIX
done  output  1  one-cycle pulse, result/RD_n_out valid
result  output  64  operation result, held until next done
RD_n_out  output  5  destination of result, held with result

Behaviour:
- States: IDLE, CALC, FIX.
- Reset (rst==0 at an edge, any state): state=IDLE, cnt=0, busy=0, done=0, result=0, RD_n_out=0, all internal accumulators cleared. Any operation in progress is discarded.
- flush=1 at an edge has priority over all else except reset: state=IDLE, done=0. result and RD_n_out keep their old values. A start on the same edge is ignored.
- IDLE, start=1 at edge E0:
  - Latch op and RD_n.
  - Latch magnitudes of operands (two's-complement absolute value for signed operands per op).
  - Latch the result sign.
  - cnt=0, go to CALC.
- IDLE, start=0: remain; done=0.
- Special cases detected in IDLE at E0 go straight to FIX with a precomputed result (done visible after E1):
  - Divide by zero: DIV/DIVU → 0xFFFF_FFFF_FFFF_FFFF; REM/REMU → read_data1.
  - Signed overflow (DIV/REM, rs1=0x8000_0000_0000_0000, rs2=all-ones): DIV → 0x8000_0000_0000_0000; REM → 0.
- CALC: one iteration per edge; cnt increments.
  - Multiply: 128-bit shift-add of the magnitudes.
  - Divide: restoring shift-subtract producing a 64-bit quotient and remainder.
  - At the edge where cnt==63, go to FIX (64 CALC edges, E1..E64).
- FIX (edge E65 normal, E1 special):
  - Apply the sign to the product, quotient or remainder.
  - Select the low 64 (MUL) or high 64 (MULH/MULHSU/MULHU) of the 128-bit product.
  - Remainder takes the dividend's sign.
  - Register result, RD_n_out; done=1 for exactly one cycle; state=IDLE.
- Latency: done high in the cycle after E65 for normal ops, after E1 for special cases.
- stall is combinational. It is high in the E0 cycle (start&IDLE) and in every CALC/FIX cycle. It is low in the cycle where done=1, so the ID/EX register advances exactly once per op.
- start while busy: ignored (upstream is stalled, so it holds).
- A back-to-back start in the done cycle is accepted (state is IDLE).
- All arithmetic is modulo 2^64 on the outputs. MULHSU treats rs1 as signed and rs2 as unsigned.

Test Plan:
- MUL rs1=7, rs2=0xFFFF_FFFF_FFFF_FFFD (-3) → result 0xFFFF_FFFF_FFFF_FFEB. done exactly 65 edges after start; stall high throughout, low in the done cycle.
- MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE. MULH same operands → 0.
- DIV rs1=-7, rs2=2 → 0xFFFF_FFFF_FFFF_FFFD (-3). REM same → 0xFFFF_FFFF_FFFF_FFFF (-1). DIVU 100/7 → 14. REMU → 2.
- DIVU rs1=0x1234, rs2=0 → all-ones, done after 1 edge. REM rs1=0x1234, rs2=0 → 0x1234. DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000, done after 1 edge.
- Flush at CALC cycle 30 → busy=0 next cycle, no done, result retains prior value. A fresh MUL 3*5 afterwards → 15.
- rst=0 mid-CALC → all outputs 0 after that edge. A start with RD_n=5 after reset releases → RD_n_out=5 at done.
